// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: PC / IF/ID / ID/EX / EX/MEM write, flush and bubble controls
// plus a saturating stall-cycle counter. Define HAZARD_MD_STALL_EN to compile in the mult/div freeze.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             imem_ready_i,
  input  logic             md_start_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             if_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [3:0] MD_CNT_INIT = 4'(MD_LAT - 1);

  logic             lu;
  logic             md_busy;
  logic             md_go;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign lu = ex_memread_i & (ex_rt_i != 5'd0) &
              ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

`ifdef HAZARD_MD_STALL_EN
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (md_start_i) begin
          state_d  = ST_MD_BUSY;
          md_cnt_d = MD_CNT_INIT;
        end
      end
      ST_MD_BUSY: begin
        // md_cnt holds the frozen cycles still to go, including this one
        md_cnt_d = md_cnt_q - 4'd1;
        if (md_cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (state_q == ST_MD_BUSY);
  assign md_go   = (state_q == ST_RUN) & md_start_i;
`else
  logic       md_start_unused;
  logic [3:0] md_lat_unused;

  assign md_start_unused = md_start_i;
  assign md_lat_unused   = MD_CNT_INIT;
  assign md_busy         = 1'b0;
  assign md_go           = 1'b0;
`endif

  // Priority: reset, mult/div freeze, mult/div launch, load-use, branch, imem wait
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    if_flush_o     = 1'b0;
    idex_write_o   = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    if (!rst_n_i) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      if_flush_o     = 1'b1;
      idex_write_o   = 1'b0;
      idex_bubble_o  = 1'b1;
      exmem_bubble_o = 1'b1;
    end else if (md_busy) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_bubble_o = 1'b1;
    end else if (md_go) begin
      pc_write_o     = 1'b1;
    end else if (lu) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_bubble_o  = 1'b1;
    end else if (branch_taken_i) begin
      if_flush_o     = 1'b1;
    end else if (!imem_ready_i) begin
      // ID gets a NOP while the same fetch address is retried
      pc_write_o     = 1'b0;
      if_flush_o     = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
